input_request_unit: RTL and testbench

- Responder for the CPU's switch-input instruction: the control unit raises cu_inSignal; this block stalls the program counter until the operator presses the enter button.
- On the press it captures the switches, returns the 16-bit value with a one-cycle valid strobe, and releases the stall.
- Sits between the board button/switches and the In Signal MUX / program counter hlt path.
- Provides the handshake the CPU currently lacks when it samples raw switches.

---
 rtl/input_request_unit.sv | 107 ++++++++++
 tb/tb_input_request_unit.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/input_request_unit.sv
// Switch-input responder for the IN instruction: stalls the PC until a
// debounced enter press, then returns the switch value with a one-cycle strobe.
module input_request_unit #(
   parameter int DEBOUNCE_CYCLES = 50000,
   parameter int DATA_WIDTH      = 16,
   parameter int CNT_WIDTH       = 16
) (
   input  logic                  clock,
   input  logic                  n_reset,
   input  logic                  cu_inSignal,
   input  logic [DATA_WIDTH-1:0] switches,
   input  logic                  button,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  data_valid,
   output logic                  stall,
   output logic                  waiting
);

   typedef enum logic [2:0] {
      IDLE,
      ARM,
      WAIT_PRESS,
      DEBOUNCE,
      CAPTURE,
      DONE
   } state_t;

   localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

   state_t               state;
   logic [CNT_WIDTH-1:0] cnt;
   logic                 btn_meta;
   logic                 btn_s;

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples pre-edge values regardless of statement order.
   always_ff @(posedge clock or negedge n_reset) begin
      if (!n_reset) begin
         btn_meta <= 1'b0;
         btn_s    <= 1'b0;
      end else begin
         btn_meta <= button;
         btn_s    <= btn_meta;
      end
   end

   always_ff @(posedge clock or negedge n_reset) begin
      if (!n_reset) begin
         state      <= IDLE;
         cnt        <= '0;
         data_out   <= '0;
         data_valid <= 1'b0;
      end else begin
         data_valid <= 1'b0;
         case (state)
            IDLE: begin
               if (cu_inSignal) state <= ARM;
            end
            ARM: begin
               if (!cu_inSignal) state <= IDLE;
               else if (!btn_s)  state <= WAIT_PRESS;
            end
            WAIT_PRESS: begin
               if (!cu_inSignal) begin
                  state <= IDLE;
               end else if (btn_s) begin
                  state <= DEBOUNCE;
                  cnt   <= '0;
               end
            end
            DEBOUNCE: begin
               // A completed run is committed even if the request drops now.
               if (btn_s && cnt == CNT_MAX) begin
                  state <= CAPTURE;
               end else if (!cu_inSignal) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else if (!btn_s) begin
                  state <= WAIT_PRESS;
                  cnt   <= '0;
               end else if (cnt != CNT_MAX) begin
                  cnt <= cnt + 1'b1;
               end
            end
            CAPTURE: begin
               data_out   <= switches;
               data_valid <= 1'b1;
               state      <= DONE;
            end
            DONE: begin
               if (!cu_inSignal) state <= IDLE;
            end
            default: state <= IDLE;
         endcase
      end
   end

   // NOTE: every output of this block gets a default first so no latch is inferred.
   always_comb begin
      stall   = 1'b0;
      waiting = 1'b0;
      // Gated by n_reset so a held request cannot assert stall while in reset.
      if (n_reset && cu_inSignal && state != DONE) stall = 1'b1;
      if (state == ARM || state == WAIT_PRESS || state == DEBOUNCE) waiting = 1'b1;
   end

endmodule

// File: tb/tb_input_request_unit.sv
// Bench for input_request_unit: vector table, directed corner sequences and
// randomized traffic against a run-length reference model.
module tb_input_request_unit;

   localparam int D  = 4;
   localparam int DW = 16;

   logic          clock = 1'b0;
   logic          n_reset;
   logic          cu_inSignal;
   logic [DW-1:0] switches;
   logic          button;
   logic [DW-1:0] data_out;
   logic          data_valid;
   logic          stall;
   logic          waiting;

   input_request_unit #(
      .DEBOUNCE_CYCLES(D),
      .DATA_WIDTH     (DW),
      .CNT_WIDTH      (16)
   ) dut (
      .clock      (clock),
      .n_reset    (n_reset),
      .cu_inSignal(cu_inSignal),
      .switches   (switches),
      .button     (button),
      .data_out   (data_out),
      .data_valid (data_valid),
      .stall      (stall),
      .waiting    (waiting)
   );

   always #5 clock = ~clock;

   int total = 0;
   int bad   = 0;
   int strobes = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: a request is "live" from acceptance until served and
   // dropped; a press is accepted after the button has been seen released and
   // then D+1 consecutive high synchronized samples (the entering sample plus D).
   logic          b1, b2;
   logic          m_req, m_rel, m_commit, m_served, m_valid;
   int            m_run;
   logic [DW-1:0] m_data;

   task automatic model_reset();
      b1 = 0; b2 = 0;
      m_req = 0; m_rel = 0; m_commit = 0; m_served = 0; m_valid = 0;
      m_run = 0; m_data = '0;
   endtask

   task automatic model_edge(input logic cu, input logic btn, input logic [DW-1:0] sw);
      logic bs;
      bs = b2; b2 = b1; b1 = btn;
      m_valid = 0;
      if (m_commit) begin
         m_data = sw; m_valid = 1; m_commit = 0; m_served = 1;
      end else if (!m_req) begin
         if (cu) begin m_req = 1; m_rel = 0; m_run = 0; end
      end else if (m_served) begin
         if (!cu) begin m_req = 0; m_served = 0; end
      end else if (!m_rel) begin
         if (!cu) m_req = 0;
         else if (!bs) begin m_rel = 1; m_run = 0; end
      end else begin
         if (bs && m_run == D) m_commit = 1;
         else if (!cu) m_req = 0;
         else m_run = bs ? m_run + 1 : 0;
      end
   endtask

   task automatic drive_edge(input logic cu, input logic btn, input logic [DW-1:0] sw);
      cu_inSignal = cu; button = btn; switches = sw;
      @(posedge clock);
      model_edge(cu, btn, sw);
      #1;
      if (data_valid === 1'b1) strobes++;
   endtask

   task automatic tick(input logic cu, input logic btn, input logic [DW-1:0] sw);
      drive_edge(cu, btn, sw);
      check("valid", 32'(data_valid), 32'(m_valid));
      check("data", 32'(data_out), 32'(m_data));
      check("stall", 32'(stall), 32'(cu & ~(m_req & m_served)));
      check("waiting", 32'(waiting), 32'(m_req & ~m_commit & ~m_served));
   endtask

   task automatic do_reset(input logic cu, input logic btn);
      n_reset = 0; cu_inSignal = cu; button = btn;
      model_reset();
      #2;
      check("rst_data", 32'(data_out), 0);
      check("rst_valid", 32'(data_valid), 0);
      check("rst_stall", 32'(stall), 0);
      check("rst_waiting", 32'(waiting), 0);
      @(posedge clock); @(posedge clock); #3;
      check("rst_hold_data", 32'(data_out), 0);
      n_reset = 1;
      #1;
      check("rel_stall", 32'(stall), 32'(cu));
      check("rel_waiting", 32'(waiting), 0);
   endtask

   typedef struct {
      logic          cu;
      logic          btn;
      logic [DW-1:0] sw;
      logic          exp_valid;
      logic [DW-1:0] exp_data;
      logic          exp_stall;
      logic          exp_wait;
   } vec_t;

   vec_t vecs[17];

   function automatic vec_t mk(logic cu, logic btn, logic v, logic [DW-1:0] d, logic s, logic w);
      vec_t r;
      r.cu = cu; r.btn = btn; r.sw = 16'hA5C3;
      r.exp_valid = v; r.exp_data = d; r.exp_stall = s; r.exp_wait = w;
      return r;
   endfunction

   initial begin
      logic          cu_r, btn_r;
      logic [DW-1:0] sw_r;
      int            s0;

      // Clean capture, pressed after 5 request cycles: strobe 7 edges after
      // the first edge that samples the button high, stall low with it.
      for (int i = 0; i < 5; i++) vecs[i] = mk(1, 0, 0, 16'h0, 1, 1);
      for (int i = 5; i < 11; i++) vecs[i] = mk(1, 1, 0, 16'h0, 1, 1);
      vecs[11] = mk(1, 1, 0, 16'h0,    1, 0);
      vecs[12] = mk(1, 1, 1, 16'hA5C3, 0, 0);
      vecs[13] = mk(1, 1, 0, 16'hA5C3, 0, 0);
      vecs[14] = mk(1, 1, 0, 16'hA5C3, 0, 0);
      vecs[15] = mk(0, 0, 0, 16'hA5C3, 0, 0);
      vecs[16] = mk(0, 0, 0, 16'hA5C3, 0, 0);

      switches = 16'hFFFF;
      do_reset(1, 1);
      do_reset(0, 0);

      foreach (vecs[i]) begin
         drive_edge(vecs[i].cu, vecs[i].btn, vecs[i].sw);
         check($sformatf("vec%0d_valid", i), 32'(data_valid), 32'(vecs[i].exp_valid));
         check($sformatf("vec%0d_data", i), 32'(data_out), 32'(vecs[i].exp_data));
         check($sformatf("vec%0d_stall", i), 32'(stall), 32'(vecs[i].exp_stall));
         check($sformatf("vec%0d_waiting", i), 32'(waiting), 32'(vecs[i].exp_wait));
      end

      // Abort mid-debounce, then a second request after a 1-cycle gap.
      strobes = 0;
      repeat (3) tick(1, 0, 16'h1111);
      repeat (4) tick(1, 1, 16'h1111);
      tick(0, 1, 16'h1111);
      check("abort_stall", 32'(stall), 0);
      check("abort_waiting", 32'(waiting), 0);
      check("abort_keep_data", 32'(data_out), 32'h0000A5C3);
      tick(1, 1, 16'h0007);
      check("rearm_waiting", 32'(waiting), 1);
      repeat (3) tick(1, 1, 16'h0007);
      check("abort_no_strobe", 32'(strobes), 0);
      repeat (4) tick(1, 0, 16'h0007);
      repeat (10) tick(1, 1, 16'h0007);
      check("second_strobes", 32'(strobes), 1);
      check("second_data", 32'(data_out), 32'h00000007);
      tick(0, 0, 16'h0007);

      // Bounce: synchronized pattern 1,1,0 then a sustained run.
      strobes = 0;
      repeat (3) tick(1, 0, 16'h1234);
      for (int k = 0; k < 13; k++) begin
         tick(1, (k == 2) ? 1'b0 : 1'b1, 16'h1234);
         if (k == 8) check("bounce_no_early", 32'(strobes), 0);
      end
      check("bounce_strobes", 32'(strobes), 1);
      check("bounce_data", 32'(data_out), 32'h00001234);
      tick(0, 1, 16'h1234);

      // Held button from the previous input: no capture until release+press.
      strobes = 0;
      repeat (3) tick(0, 1, 16'hBEEF);
      repeat (8) tick(1, 1, 16'hBEEF);
      check("held_waiting", 32'(waiting), 1);
      check("held_no_strobe", 32'(strobes), 0);
      repeat (3) tick(1, 0, 16'hBEEF);
      repeat (10) tick(1, 1, 16'hBEEF);
      check("held_strobes", 32'(strobes), 1);
      check("held_data", 32'(data_out), 32'h0000BEEF);
      tick(0, 0, 16'hBEEF);

      // Reset in the middle of a debounce run.
      repeat (3) tick(1, 0, 16'h5555);
      repeat (4) tick(1, 1, 16'h5555);
      s0 = strobes;
      do_reset(1, 1);
      check("midrst_no_strobe", 32'(strobes), 32'(s0));
      tick(0, 0, 16'h5555);

      // Randomized traffic against the model.
      cu_r = 0; btn_r = 0;
      strobes = 0;
      for (int n = 0; n < 4000; n++) begin
         if ($urandom_range(0, 39) == 0) cu_r = ~cu_r;
         if ($urandom_range(0, 5) == 0) btn_r = ~btn_r;
         sw_r = DW'($urandom);
         tick(cu_r, btn_r, sw_r);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
